// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants, types and helpers for the seven-segment display path
package sevenseg_pkg;

    localparam int DIGIT_W            = 4;
    localparam int MAX_DIGITS         = 8;
    localparam int NUM_DIGITS_DEFAULT = 4;

    typedef logic [DIGIT_W-1:0] nibble_t;

    // Anode enable pattern for one digit; callers keep the low NUM_DIGITS bits
    function automatic logic [MAX_DIGITS-1:0] onehot_digit(input logic [2:0] index);
        return MAX_DIGITS'(1) << index;
    endfunction

endpackage

// File: rtl/sevenseg_scan_timer.sv
// rtl/sevenseg_scan_timer.sv - slot counter and digit index for display scanning
module sevenseg_scan_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    localparam int CNT_W       = $clog2(REFRESH_DIV),
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [IDX_W-1:0] index_o,      // digit index after the coming edge
    output logic             in_blank_o,   // slot phase after the coming edge is BLANK
    output logic             frame_wrap_o  // the coming edge wraps the index to digit 0
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_wrap;

    // Next counter/index; outputs expose next-state so downstream registers line up with the counter
    always_comb begin
        slot_wrap = (cnt_q == CNT_LAST);
        cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    assign index_o      = idx_d;
    assign frame_wrap_o = slot_wrap && (idx_q == IDX_LAST);

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank_o = 1'b0;
        end else begin : g_blank
            assign in_blank_o = (32'(cnt_d) < BLANK_CYCLES);
        end
    endgenerate

    // Counter and index state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/sevenseg_scan_mux.sv
// rtl/sevenseg_scan_mux.sv - multiplexes a multi-digit hex value onto a common-segment display
module sevenseg_scan_mux
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEFAULT,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_i,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in_i,
    input  logic [NUM_DIGITS-1:0]         dp_in_i,
    input  logic                          blank_lz_i,
    output logic                          load_ack_o,
    output logic [DIGIT_W-1:0]            digit_nibble_o,
    output logic                          dp_o,
    output logic [NUM_DIGITS-1:0]         an_o
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = DIGIT_W * NUM_DIGITS;

    logic [IDX_W-1:0]      idx;
    logic                  in_blank;
    logic                  frame_wrap;

    logic [VAL_W-1:0]      shown_q, shown_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0] sdp_q, sdp_d, pdp_q, pdp_d;
    logic                  pflag_q, pflag_d;

    logic                  ack_q, ack_d;
    nibble_t               nib_q, nib_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [VAL_W-1:0]      upper;
    logic                  suppressed;

    sevenseg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .index_o      (idx),
        .in_blank_o   (in_blank),
        .frame_wrap_o (frame_wrap)
    );

    // Handshake: boundary promotes the old pending value; a load on the same edge refills pending
    always_comb begin
        shown_d = shown_q;
        sdp_d   = sdp_q;
        pend_d  = pend_q;
        pdp_d   = pdp_q;
        pflag_d = pflag_q;
        ack_d   = frame_wrap && pflag_q;
        if (frame_wrap && pflag_q) begin
            shown_d = pend_q;
            sdp_d   = pdp_q;
            pflag_d = 1'b0;
        end
        if (load_i) begin
            pend_d  = value_in_i;
            pdp_d   = dp_in_i;
            pflag_d = 1'b1;
        end
    end

    // Display decode from the value that will be shown after this edge
    always_comb begin
        upper      = shown_d >> {idx, 2'b00};
        suppressed = blank_lz_i && (idx != '0) && (upper == '0);
        nib_d      = upper[DIGIT_W-1:0];
        an_d       = '0;
        dp_d       = 1'b0;
        if (!in_blank && !suppressed) begin
            an_d = NUM_DIGITS'(onehot_digit(3'(idx)));
            dp_d = sdp_d[idx];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shown_q <= '0;
            sdp_q   <= '0;
            pend_q  <= '0;
            pdp_q   <= '0;
            pflag_q <= 1'b0;
            ack_q   <= 1'b0;
            nib_q   <= '0;
            dp_q    <= 1'b0;
            an_q    <= '0;
        end else begin
            shown_q <= shown_d;
            sdp_q   <= sdp_d;
            pend_q  <= pend_d;
            pdp_q   <= pdp_d;
            pflag_q <= pflag_d;
            ack_q   <= ack_d;
            nib_q   <= nib_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign load_ack_o     = ack_q;
    assign digit_nibble_o = nib_q;
    assign dp_o           = dp_q;
    assign an_o           = an_q;

endmodule

// File: doc/sevenseg_scan_mux.md
Name: sevenseg_scan_mux

Overview:
- Upstream stage of the team's 4-bit-to-7-segment decoder.
- Holds a multi-digit hex value and time-multiplexes it onto a common-segment display.
- Each refresh slot presents one digit's nibble to the decoder and enables that digit's anode, with a short blanking guard against ghosting.
- New values are accepted through a load/ack handshake and applied only at a frame boundary, so the display never shows a torn value.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (must be > BLANK_CYCLES).
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off (0 allowed).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  request to display value_in/dp_in; sampled every cycle.
- value_in  input  4*NUM_DIGITS  hex digits; digit 0 = bits [3:0].
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_lz  input  1  1 = suppress leading zero digits.
- load_ack  output  1  one-cycle pulse when the pending value becomes the shown value.
- digit_nibble  output  4  nibble for the decoder's control_input.
- dp  output  1  decimal point of the active digit, 1 = lit.
- an  output  NUM_DIGITS  digit enables, active-high, at most one bit set.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): slot counter=0, digit index=0, shown value/dp=0, pending value/dp=0, pending flag=0.
  - Outputs at reset: load_ack=0, digit_nibble=0, dp=0, an=0.
- Slot counter: counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index increments modulo NUM_DIGITS.
  - Index wrap NUM_DIGITS-1 -> 0 is the frame boundary.
- Per-slot states, decoded from the counter:
  - BLANK while counter < BLANK_CYCLES: an=0, dp=0, digit_nibble = nibble of the current index.
  - ON otherwise: an = one-hot(index) unless that digit is suppressed.
- Output timing: all outputs are registered and reflect the counter/index values after the same clock edge (no extra latency).
  - First slot after reset release: digit 0, BLANK phase.
- Load handshake:
  - load=1 on a cycle captures value_in/dp_in into pending and sets the pending flag.
  - A later load before the frame boundary overwrites pending (last writer wins); only one ack is issued.
- Frame boundary with pending flag=1, on the same edge as the index wrap:
  - shown <= pending, pending flag clears, load_ack=1 for exactly one cycle.
  - digit_nibble and dp for digit 0 come from the new shown value.
- Frame boundary with pending flag=0: load_ack stays 0 and shown is unchanged.
- Simultaneous load and frame boundary: the boundary applies the previously pending contents (if any) and acks it.
  - The newly captured value becomes pending for the next frame.
  - If nothing was pending, the new value is not applied this boundary.
- Leading-zero blanking (blank_lz=1):
  - Digit k (k>0) is suppressed when shown digits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit has an=0 and dp=dp_shown[k] masked to 0 for its whole slot.
  - blank_lz is sampled live, every cycle.
- Unsigned arithmetic throughout; the counter width is clog2(REFRESH_DIV).

Decomposition:
- Package sevenseg_pkg holds:
  - localparam DIGIT_W=4;
  - typedef logic [DIGIT_W-1:0] nibble_t;
  - function onehot_digit(index);
  - default NUM_DIGITS constant, shared with the decoder top.
- One sub-module, sevenseg_scan_timer: slot counter plus digit index, with outputs index, in_blank, frame_wrap.
- Blanking and handshake logic stay in sevenseg_scan_mux.
- The display top instantiates sevenseg_scan_mux and the decoder side by side.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, frame=32 cycles):
- Reset, then idle 64 cycles -> digit_nibble=0 throughout, an pattern 0001 during slot-0 cycles 2..7, 0010 during cycles 10..15, etc.; an=0 in all BLANK cycles; load_ack never 1.
- load=1 at cycle 5 with value_in=16'h1234, dp_in=4'b0100 -> load_ack=1 only at cycle 32; digit_nibble=4 from cycle 32, 3 at cycle 40; dp=1 only during cycles 50..55.
- load 16'hAAAA at cycle 3, then load 16'h00F0 at cycle 20 -> single load_ack at cycle 32; shown=16'h00F0; no frame ever displays AAAA.
- blank_lz=1 with shown=16'h0070 -> digits 0,1 lit (nibbles 0,7); digits 2,3 give an=0 for whole slots; shown=16'h0000 -> only digit 0 lit.
- load coinciding with frame boundary (cycle 31->32 edge) and nothing pending -> no ack at 32; ack at 64 with the new value.
- rst asserted at cycle 45 mid-ON phase -> outputs 0 immediately (asynchronously); pending discarded; restart at digit 0 BLANK after release.
